// File: rtl/router_pkt_receiver.sv
// router_pkt_receiver
//
// Destination-side consumer for one router output port. It drains the port
// FIFO, parses each packet (header, payload, parity) and presents the payload
// bytes to the local client as a strobed byte stream. It also checks parity
// and the destination address, and keeps packet and error statistics.
//
// Packet format:
//   header  : [7:2] payload length 0..63, [1:0] destination address
//   payload : 0..63 bytes
//   parity  : XOR of the header and every payload byte
//
// Ports:
//   clk         rising-edge clock
//   resetn      asynchronous active-low reset, clears all state
//   empty       FIFO empty flag
//   data_in     FIFO data_out (registered, valid the cycle after a read)
//   abort       synchronous FIFO soft reset, abandons the current packet
//   hold        client backpressure, blocks new reads only
//   read_enb    FIFO read strobe (combinational)
//   rx_data     payload byte, qualified by rx_valid, 0 otherwise
//   rx_valid    one-cycle strobe per payload byte
//   pkt_done    one-cycle strobe while the parity byte is on data_in
//   parity_err  with pkt_done: accumulated parity differs from parity byte
//   addr_err    with pkt_done: header address differs from PORT_ADDR
//   pkt_len     length field of the current or last header
//   busy        high whenever a packet is in progress
//   pkt_cnt     completed packets, wraps
//   err_cnt     errored packets plus aborts of a busy receiver, saturates
//
// State table:
//   state    | meaning
//   IDLE     | no packet in progress, header read allowed
//   HDR_WAIT | header read issued, waiting for the header byte on data_in
//   BODY     | issuing and receiving payload bytes and the parity byte

module router_pkt_receiver #(
  parameter int         WIDTH     = 8,
  parameter logic [1:0] PORT_ADDR = 2'b00
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             empty,
  input  logic [WIDTH-1:0] data_in,
  input  logic             abort,
  input  logic             hold,
  output logic             read_enb,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             pkt_done,
  output logic             parity_err,
  output logic             addr_err,
  output logic [5:0]       pkt_len,
  output logic             busy,
  output logic [7:0]       pkt_cnt,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HDR_WAIT = 2'd1,
    BODY     = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  // pend marks that data_in holds the byte of the previous cycle's read
  logic             pend;
  logic [WIDTH-1:0] acc;
  logic             addr_err_r;
  logic [6:0]       issue_left;
  logic [6:0]       recv_left;

  logic             rd_allowed;
  logic             capture;
  logic             hdr_cap;
  logic             body_cap;
  logic             last_cap;
  logic             err_any;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    rd_allowed = 1'b0;

    case (state)
      IDLE:     rd_allowed = 1'b1;
      HDR_WAIT: rd_allowed = 1'b0;
      BODY:     rd_allowed = (issue_left != 7'd0);
      default:  rd_allowed = 1'b0;
    endcase

    // Gating with resetn keeps the FIFO untouched while reset is held,
    // since IDLE would otherwise allow a read during reset.
    read_enb = resetn & rd_allowed & ~empty & ~hold & ~abort;

    // An abort drops whatever byte is on data_in this cycle.
    capture  = pend & ~abort;
    hdr_cap  = capture & (state == HDR_WAIT);
    body_cap = capture & (state == BODY);
    last_cap = body_cap & (recv_left == 7'd1);

    rx_valid   = body_cap & (recv_left > 7'd1);
    rx_data    = rx_valid ? data_in : '0;
    pkt_done   = last_cap;
    parity_err = last_cap & (acc != data_in);
    addr_err   = last_cap & addr_err_r;
    err_any    = parity_err | addr_err;
    busy       = (state != IDLE);

    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (read_enb) begin
            state_nxt = HDR_WAIT;
          end
        end
        HDR_WAIT: begin
          if (hdr_cap) begin
            state_nxt = BODY;
          end
        end
        BODY: begin
          if (last_cap) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Packet datapath: header fields, parity accumulator, byte budgets.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend       <= 1'b0;
      pkt_len    <= 6'd0;
      acc        <= '0;
      addr_err_r <= 1'b0;
      issue_left <= 7'd0;
      recv_left  <= 7'd0;
    end else begin
      pend <= read_enb;

      if (hdr_cap) begin
        pkt_len    <= data_in[7:2];
        acc        <= data_in;
        addr_err_r <= (data_in[1:0] != PORT_ADDR);
        // payload bytes plus the trailing parity byte
        issue_left <= {1'b0, data_in[7:2]} + 7'd1;
        recv_left  <= {1'b0, data_in[7:2]} + 7'd1;
      end

      if (read_enb && (state == BODY)) begin
        issue_left <= issue_left - 7'd1;
      end

      if (body_cap) begin
        recv_left <= recv_left - 7'd1;
        if (rx_valid) begin
          acc <= acc ^ data_in;
        end
      end
    end
  end

  // Statistics. pkt_done and abort are mutually exclusive in a cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pkt_cnt <= 8'd0;
      err_cnt <= 8'd0;
    end else if (abort) begin
      if (busy && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end else if (last_cap) begin
      pkt_cnt <= pkt_cnt + 8'd1;
      if (err_any && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: doc/router_pkt_receiver.md
# router_pkt_receiver

- Destination-side consumer for one router output port: drains the port FIFO, parses each packet, and presents payload bytes to the local client as a strobed byte stream.
- Packet format is header, payload, then parity:
  - Header is one byte: bits [7:2] = payload length 0..63, bits [1:0] = destination address.
  - Parity is one byte: the XOR of the header and every payload byte.
- Checks parity and destination address per packet and keeps packet/error statistics.
- Sits between one FIFO output (data_out/empty) and the client logic, one instance per router port.

## Interface
- WIDTH, 8, byte width; header field positions assume 8.
- PORT_ADDR, 2'b00, expected destination address for this port.
- clk  in  1  single clock, rising edge.
- resetn  in  1  reset, asynchronous and active-low; clears all state.
- empty  in  1  FIFO empty flag.
- data_in  in  WIDTH  FIFO data_out, registered; valid the cycle after a read with ~empty.
- abort  in  1  synchronous; FIFO soft reset for this port; abandons the current packet.
- hold  in  1  client backpressure; while high, no new reads are issued.
- read_enb  out  1  FIFO read strobe; combinational.
- rx_data  out  WIDTH  payload byte.
- rx_valid  out  1  one-cycle strobe per payload byte.
- pkt_done  out  1  one-cycle strobe when the parity byte is captured.
- parity_err  out  1  valid with pkt_done; computed parity ≠ received parity.
- addr_err  out  1  valid with pkt_done; header[1:0] ≠ PORT_ADDR.
- pkt_len  out  6  header[7:2] of the current or last packet.
- busy  out  1  high in any state other than IDLE.
- pkt_cnt  out  8  packets completed; wraps 255→0.
- err_cnt  out  8  count of packets with parity_err or addr_err, plus aborts; saturates at 255.

## Operation
- **States:**
  - **IDLE:** wait for a header.
  - **HDR_WAIT:** header read issued, waiting for the header capture.
  - **BODY:** payload and parity reads.
- **Read gating:**
  - read_enb = rd_allowed & ~empty & ~hold.
  - rd_allowed is derived from registered state only.
  - Each read_enb=1 cycle sets pend (registered); when pend=1, data_in is captured on the next edge.
- **IDLE:**
  - rd_allowed=1.
  - The first read moves to HDR_WAIT.
  - No further reads are issued until the header is captured.
- **HDR_WAIT:**
  - rd_allowed=0.
  - On capture: pkt_len←data_in[7:2]; parity accumulator←data_in; addr_err_r←(data_in[1:0]≠PORT_ADDR).
  - issue_left←pkt_len+1 and recv_left←pkt_len+1, both 7-bit.
  - Go to BODY.
- **BODY:**
  - rd_allowed = (issue_left≠0); issue_left decrements on each read_enb.
  - Each capture decrements recv_left.
  - A capture with recv_left>1 is a payload byte: rx_data←byte, rx_valid=1, accumulator^=byte.
  - The capture with recv_left==1 is the parity byte:
    - pkt_done=1; parity_err=(acc≠byte); addr_err=addr_err_r.
    - pkt_cnt+1; err_cnt+1 (saturating) if either error is set.
    - Go to IDLE.
- **Zero-length header:** recv_left=1, so only the parity byte is read; pkt_done fires with no rx_valid.
- **Address mismatch:** the packet is still fully drained, and its payload is still presented on rx_data.
- **abort=1:**
  - Takes priority over everything in that cycle.
  - Next state is IDLE; pend is cleared and any in-flight capture is dropped.
  - read_enb is forced to 0 in that cycle.
  - No rx_valid or pkt_done; err_cnt+1 (saturating) if busy was 1.
- **hold:**
  - Affects issuing only.
  - A read already issued is still captured and strobed.

## Timing
- **Reset values:** all outputs 0; state IDLE; pend=0; counters 0.
- **Latency:** read_enb at cycle N → capture at edge N+1 → rx_valid/pkt_done high during cycle N+1.
- **Throughput:**
  - Payload and parity bytes: 1 byte/cycle when ~empty and ~hold.
  - Header: costs 2 cycles (read, then wait).
  - Minimum packet of length L takes L+3 cycles from the first read_enb to pkt_done.
- **Back-to-back packets:** a new header read may issue in the cycle after pkt_done.
- **Empty gaps:** empty toggling mid-packet only stalls; no byte is lost or duplicated.
- **Concurrent read and capture:** read_enb and a capture in the same cycle are normal.
- **Status outputs:**
  - pkt_len updates one cycle after the header capture.
  - parity_err and addr_err are meaningful only while pkt_done=1 and are 0 otherwise.
- **Async reset mid-packet:** immediate return to reset values. Counters are not preserved.

## Test plan
- **Nominal packet:** header 8'h0C (len 3, addr 0), payload 11,22,33, parity 8'h0C^11^22^33=8'h0C. Expect:
  - rx_valid ×3 with 11,22,33.
  - pkt_done, parity_err=0, addr_err=0.
  - pkt_cnt=1, pkt_len=3.
  - 6 cycles from first read_enb to pkt_done.
- **Parity and address errors:**
  - Same packet with parity 8'h00 → parity_err=1 with pkt_done, err_cnt=1.
  - Header 8'h0D with PORT_ADDR=0 → addr_err=1, all 3 payload bytes still strobed.
- **Stall and backpressure:** empty toggled every other cycle and hold high for 4 cycles mid-payload → identical byte sequence; no read_enb while hold=1 or empty=1.
- **Abort mid-packet:** abort after 2 of 5 payload bytes → busy=0 next cycle, no pkt_done, err_cnt+1; the next clean packet is received correctly.
- **Length extremes and counter wrap:**
  - Length 0 (header 8'h00, parity 8'h00) → pkt_done with no rx_valid.
  - Length 63 → 63 strobes.
  - 256 packets → pkt_cnt wraps to 0.
- **Async reset mid-body:** resetn low mid-payload → all outputs 0 immediately; read_enb=0 until resetn rises.
